data_memory_mmio: RTL and testbench

//   Parametrised data-memory subsystem for the 16-bit computer: general RAM, a screen

---
 rtl/dm_pkg.sv | 16 +
 rtl/dm_screen_ram.sv | 32 +++
 rtl/data_memory_mmio.sv | 92 +++++++++
 tb/tb_data_memory_mmio.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: address map, fill-engine states and region decode for the data memory subsystem
package dm_pkg;
    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 15;
    localparam int RAM_WORDS    = 16384;
    localparam int SCREEN_BASE  = 16384;
    localparam int SCREEN_WORDS = 8192;
    localparam int KBD_ADDR     = 24576;

    typedef enum logic {IDLE, FILL} fill_state_t;
    typedef enum logic [1:0] {RG_RAM, RG_SCR, RG_KBD, RG_NONE} region_t;

    function automatic region_t decode(input int adr, input int screen_base, input int kbd_addr);
        return adr < screen_base ? RG_RAM : adr < kbd_addr ? RG_SCR : adr == kbd_addr ? RG_KBD : RG_NONE;
    endfunction
endpackage

// File: rtl/dm_screen_ram.sv
// dm_screen_ram: screen array with one shared write port, a CPU read port and a scan read port, read-old-data
module dm_screen_ram #(
    parameter int DATA_W = 16,
    parameter int AW     = 13,
    parameter int WORDS  = 8192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     wadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     radr,
    output logic [DATA_W-1:0] rdata,
    input  logic [AW-1:0]     scan_adr,
    output logic [DATA_W-1:0] scan_data
);
    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[wadr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata     <= '0;
            scan_data <= '0;
        end else begin
            rdata     <= mem[radr];
            scan_data <= mem[scan_adr];
        end
    end
endmodule

// File: rtl/data_memory_mmio.sv
// data_memory_mmio: CPU data space of RAM, screen frame buffer and keyboard register, with screen-fill engine
module data_memory_mmio #(
    parameter int DATA_W       = dm_pkg::DATA_W,
    parameter int ADDR_W       = dm_pkg::ADDR_W,
    parameter int RAM_WORDS    = dm_pkg::RAM_WORDS,
    parameter int SCREEN_BASE  = dm_pkg::SCREEN_BASE,
    parameter int SCREEN_WORDS = dm_pkg::SCREEN_WORDS,
    parameter int KBD_ADDR     = dm_pkg::KBD_ADDR,
    parameter int SCR_AW       = $clog2(SCREEN_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic [SCR_AW-1:0] scan_adr,
    output logic [DATA_W-1:0] scan_data,
    input  logic [DATA_W-1:0] kb_in,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_pattern,
    output logic              clr_busy,
    output logic              clr_done
);
    import dm_pkg::*;

    localparam int RAM_AW = $clog2(RAM_WORDS);

    region_t           rg, rg_q;
    fill_state_t       state, state_n;
    logic [SCR_AW-1:0] cnt, scr_off;
    logic [DATA_W-1:0] pattern, kb_reg, kb_q, ram_q, scr_q;
    logic [DATA_W-1:0] ram [RAM_WORDS];
    logic              last, scr_we;

    assign rg       = decode(32'(adr), SCREEN_BASE, KBD_ADDR);
    assign scr_off  = SCR_AW'(adr - ADDR_W'(SCREEN_BASE));
    assign clr_busy = state == FILL;
    assign last     = clr_busy && cnt == SCR_AW'(SCREEN_WORDS - 1);
    // fill owns the write port; a reset edge mid-fill must not land one more word
    assign scr_we   = clr_busy ? rst_n : load && rg == RG_SCR;

    always_comb begin
        state_n = clr_busy ? (last ? IDLE : FILL) : (clr_start ? FILL : IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_done <= 1'b0;
            kb_reg   <= '0;
            rg_q     <= RG_NONE;
        end else begin
            state    <= state_n;
            clr_done <= last;
            kb_reg   <= kb_in;
            rg_q     <= rg;
        end
    end

    always_ff @(posedge clk) begin
        kb_q <= kb_reg;
        if (!clr_busy && clr_start) begin
            pattern <= clr_pattern;
            cnt     <= '0;
        end else if (clr_busy) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load && rg == RG_RAM) ram[adr[RAM_AW-1:0]] <= d_in;
        ram_q <= ram[adr[RAM_AW-1:0]];
    end

    dm_screen_ram #(.DATA_W(DATA_W), .AW(SCR_AW), .WORDS(SCREEN_WORDS)) u_screen (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (scr_we),
        .wadr     (clr_busy ? cnt : scr_off),
        .wdata    (clr_busy ? pattern : d_in),
        .radr     (scr_off),
        .rdata    (scr_q),
        .scan_adr (scan_adr),
        .scan_data(scan_data)
    );

    // rg_q is reset to RG_NONE, so d_out reads 0 straight after reset
    always_comb begin
        d_out = rg_q == RG_RAM ? ram_q : rg_q == RG_SCR ? scr_q : rg_q == RG_KBD ? kb_q : '0;
    end
endmodule

// File: tb/tb_data_memory_mmio.sv
// tb_data_memory_mmio: directed vector table plus fill and reset-abort sequences for data_memory_mmio
module tb_data_memory_mmio;
    import dm_pkg::*;

    localparam int SB  = SCREEN_BASE;
    localparam int KBD = KBD_ADDR;

    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, clr_start = 1'b0;
    logic        clr_busy, clr_done;
    logic [14:0] adr = '0;
    logic [15:0] d_in = '0, kb_in = '0, clr_pattern = '0, d_out, scan_data;
    logic [12:0] scan_adr = '0;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic        ld;
        int          a;
        logic [15:0] din;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [19];

    data_memory_mmio dut (
        .clk(clk), .rst_n(rst_n), .load(load), .adr(adr), .d_in(d_in), .d_out(d_out),
        .scan_adr(scan_adr), .scan_data(scan_data), .kb_in(kb_in), .clr_start(clr_start),
        .clr_pattern(clr_pattern), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int n, bad;
        logic early;
        vecs = '{
            '{1'b1, 100,     16'h1234, 1'b0, 16'h0000},
            '{1'b0, 100,     16'h0000, 1'b1, 16'h1234},
            '{1'b1, 101,     16'h00FF, 1'b0, 16'h0000},
            '{1'b1, 100,     16'h5678, 1'b1, 16'h1234},
            '{1'b0, 100,     16'h0000, 1'b1, 16'h5678},
            '{1'b0, 101,     16'h0000, 1'b1, 16'h00FF},
            '{1'b1, SB+5,    16'hBEEF, 1'b0, 16'h0000},
            '{1'b0, SB+5,    16'h0000, 1'b1, 16'hBEEF},
            '{1'b0, KBD,     16'h0000, 1'b1, 16'h0041},
            '{1'b1, KBD,     16'hFFFF, 1'b1, 16'h0041},
            '{1'b0, KBD,     16'h0000, 1'b1, 16'h0041},
            '{1'b1, KBD+1,   16'h1111, 1'b1, 16'h0000},
            '{1'b0, KBD+1,   16'h0000, 1'b1, 16'h0000},
            '{1'b0, 32767,   16'h0000, 1'b1, 16'h0000},
            '{1'b1, 16383,   16'hCAFE, 1'b0, 16'h0000},
            '{1'b0, 16383,   16'h0000, 1'b1, 16'hCAFE},
            '{1'b1, 24575,   16'h0BAD, 1'b0, 16'h0000},
            '{1'b0, 24575,   16'h0000, 1'b1, 16'h0BAD},
            '{1'b0, SB+5,    16'h0000, 1'b1, 16'hBEEF}
        };
        step();
        step();
        check("rst_d_out", d_out, 16'h0);
        check("rst_scan_data", scan_data, 16'h0);
        check("rst_busy", {15'h0, clr_busy}, 16'h0);
        check("rst_done", {15'h0, clr_done}, 16'h0);

        rst_n = 1'b1;
        kb_in = 16'h0041;
        adr   = 15'(KBD);
        step();
        check("kbd_lag1", d_out, 16'h0000);
        step();
        check("kbd_lag2", d_out, 16'h0041);

        for (int i = 0; i < 19; i++) begin
            load = vecs[i].ld;
            adr  = 15'(vecs[i].a);
            d_in = vecs[i].din;
            step();
            if (vecs[i].chk) check($sformatf("vec%0d", i), d_out, vecs[i].exp);
        end
        load = 1'b0;

        scan_adr = 13'd5;
        adr      = 15'(SB + 5);
        step();
        check("scan_read", scan_data, 16'hBEEF);
        load = 1'b1;
        d_in = 16'h0001;
        step();
        check("scan_collision_old", scan_data, 16'hBEEF);
        check("cpu_collision_old", d_out, 16'hBEEF);
        load = 1'b0;
        step();
        check("scan_after_write", scan_data, 16'h0001);
        check("cpu_after_write", d_out, 16'h0001);

        adr         = 15'd100;
        clr_pattern = 16'h5555;
        clr_start   = 1'b1;
        step();
        clr_start   = 1'b0;
        clr_pattern = 16'h1111;
        n = 0;
        early = 1'b0;
        while (clr_busy && n < 9000) begin
            if (clr_done) early = 1'b1;
            load      = n == 3 || n == 4;
            adr       = n == 3 ? 15'(SB) : 15'd200;
            d_in      = n == 3 ? 16'hAAAA : 16'h7777;
            clr_start = n == 5;
            n++;
            step();
        end
        load      = 1'b0;
        clr_start = 1'b0;
        check("fill_busy_cycles", 16'(n), 16'd8192);
        check("fill_done_pulse", {15'h0, clr_done}, 16'h1);
        check("fill_done_early", {15'h0, early}, 16'h0);
        step();
        check("fill_done_clear", {15'h0, clr_done}, 16'h0);
        check("fill_not_restarted", {15'h0, clr_busy}, 16'h0);

        bad = 0;
        for (int i = 0; i < SCREEN_WORDS; i++) begin
            scan_adr = 13'(i);
            step();
            if (scan_data !== 16'h5555) begin
                if (bad < 4) $display("screen word %0d = %h after fill", i, scan_data);
                bad++;
            end
        end
        check("fill_words_bad", 16'(bad), 16'd0);

        adr = 15'd100;
        step();
        check("ram100_kept", d_out, 16'h5678);
        adr = 15'd200;
        step();
        check("ram200_during_fill", d_out, 16'h7777);
        adr = 15'(SB);
        step();
        check("scr_write_dropped", d_out, 16'h5555);
        adr = 15'd16383;
        step();
        check("ram_last_kept", d_out, 16'hCAFE);

        clr_pattern = 16'h3C3C;
        clr_start   = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        check("abort_busy", {15'h0, clr_busy}, 16'h0);
        check("abort_done", {15'h0, clr_done}, 16'h0);
        check("abort_d_out", d_out, 16'h0);
        check("abort_scan", scan_data, 16'h0);
        rst_n = 1'b1;
        step();
        check("abort_no_done", {15'h0, clr_done}, 16'h0);
        for (int i = 0; i <= 10; i++) begin
            scan_adr = 13'(i);
            step();
            check($sformatf("abort_word%0d", i), scan_data, i < 10 ? 16'h3C3C : 16'h5555);
        end
        scan_adr = 13'd8191;
        step();
        check("abort_word8191", scan_data, 16'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
